delay_channel: RTL and testbench

//   Fixed-latency transport channel modelling a link between two servers.

---
 rtl/delay_channel_if.sv | 18 +
 rtl/delay_channel.sv | 84 ++++++++
 tb/tb_delay_channel.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/delay_channel_if.sv
// Handshake-free link bundle for delay_channel; valid pair present only with DELAY_CHANNEL_VALID_EN.
// master = sender side (drives data_in), slave = channel side (drives data_out).
interface delay_channel_if #(
    parameter int DWIDTH = 32
);
    logic [DWIDTH-1:0] data_in;
    logic [DWIDTH-1:0] data_out;
`ifdef DELAY_CHANNEL_VALID_EN
    logic              valid_in;
    logic              valid_out;

    modport master (output data_in, output valid_in, input data_out, input valid_out);
    modport slave  (input data_in, input valid_in, output data_out, output valid_out);
`else
    modport master (output data_in, input data_out);
    modport slave  (input data_in, output data_out);
`endif
endinterface

// File: rtl/delay_channel.sv
// Fixed-latency link between ring servers; optional valid sideband under DELAY_CHANNEL_VALID_EN.
// Latency: word sampled at edge k is on data_out after edge k+DELAY-1 (DELAY-stage chain).
// Backpressure: none; one word accepted every cycle, never stalls.
module delay_channel #(
    parameter int DWIDTH = 32,
    parameter int DELAY  = 100
) (
    input  logic            clk,
    input  logic            rst,
    delay_channel_if.slave  ch
);
`ifdef DELAY_CHANNEL_VALID_EN
    localparam int VW = 1;
`else
    localparam int VW = 0;
`endif
    localparam int PW = DWIDTH + VW;

    logic [PW-1:0] word_in;
    logic [PW-1:0] word_q;

`ifdef DELAY_CHANNEL_VALID_EN
    assign word_in      = {ch.valid_in, ch.data_in};
    assign ch.valid_out = word_q[PW-1];
`else
    assign word_in      = ch.data_in;
`endif
    assign ch.data_out  = word_q[DWIDTH-1:0];

    generate
        if (DELAY < 1) begin : g_bad
            $error("delay_channel: DELAY must be >= 1");
        end else if (DELAY == 1) begin : g_d1
            always_ff @(posedge clk or posedge rst) begin
                if (rst) word_q <= '0;
                else     word_q <= word_in;
            end
        end else begin : g_dn
            localparam int CW = $clog2(DELAY);

            logic [CW-1:0] fill_cnt;
            logic          primed;
            logic [PW-1:0] tap;

            // Storage is never reset, so stale contents are hidden until the
            // first post-reset word has travelled all the way through.
            assign primed = (fill_cnt == CW'(DELAY - 1));

            always_ff @(posedge clk or posedge rst) begin
                if (rst)         fill_cnt <= '0;
                else if (!primed) fill_cnt <= fill_cnt + 1'b1;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) word_q <= '0;
                else     word_q <= primed ? tap : '0;
            end

            if (DELAY == 2) begin : g_d2
                logic [PW-1:0] stage_q;
                always_ff @(posedge clk) stage_q <= word_in;
                assign tap = stage_q;
            end else begin : g_ring
                localparam int DEPTH = DELAY - 1;
                localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

                logic [PW-1:0] mem [DEPTH];
                logic [AW-1:0] ptr;

                // Shared read/write pointer: the entry read out this edge is
                // the one overwritten, giving exactly DEPTH edges of storage.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst)                         ptr <= '0;
                    else if (ptr == AW'(DEPTH - 1))  ptr <= '0;
                    else                             ptr <= ptr + 1'b1;
                end

                always_ff @(posedge clk) mem[ptr] <= word_in;

                assign tap = mem[ptr];
            end
        end
    endgenerate
endmodule

// File: tb/tb_delay_channel.sv
module tb_delay_channel;
    localparam int N = 6;
    localparam int DLY [N] = '{1, 2, 3, 4, 5, 100};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] din [N];
    logic [31:0] obs [N];
    logic        vin;

    delay_channel_if #(.DWIDTH(8))  i0 ();
    delay_channel_if #(.DWIDTH(8))  i1 ();
    delay_channel_if #(.DWIDTH(8))  i2 ();
    delay_channel_if #(.DWIDTH(8))  i3 ();
    delay_channel_if #(.DWIDTH(8))  i4 ();
    delay_channel_if #(.DWIDTH(32)) i5 ();

    delay_channel #(.DWIDTH(8),  .DELAY(1))   u_d1   (.clk(clk), .rst(rst), .ch(i0));
    delay_channel #(.DWIDTH(8),  .DELAY(2))   u_d2   (.clk(clk), .rst(rst), .ch(i1));
    delay_channel #(.DWIDTH(8),  .DELAY(3))   u_d3   (.clk(clk), .rst(rst), .ch(i2));
    delay_channel #(.DWIDTH(8),  .DELAY(4))   u_d4   (.clk(clk), .rst(rst), .ch(i3));
    delay_channel #(.DWIDTH(8),  .DELAY(5))   u_d5   (.clk(clk), .rst(rst), .ch(i4));
    delay_channel #(.DWIDTH(32), .DELAY(100)) u_d100 (.clk(clk), .rst(rst), .ch(i5));

    assign i0.data_in = din[0][7:0];
    assign i1.data_in = din[1][7:0];
    assign i2.data_in = din[2][7:0];
    assign i3.data_in = din[3][7:0];
    assign i4.data_in = din[4][7:0];
    assign i5.data_in = din[5];

    assign obs[0] = {24'h0, i0.data_out};
    assign obs[1] = {24'h0, i1.data_out};
    assign obs[2] = {24'h0, i2.data_out};
    assign obs[3] = {24'h0, i3.data_out};
    assign obs[4] = {24'h0, i4.data_out};
    assign obs[5] = i5.data_out;

`ifdef DELAY_CHANNEL_VALID_EN
    assign i0.valid_in = 1'b0;
    assign i1.valid_in = 1'b0;
    assign i2.valid_in = vin;
    assign i3.valid_in = 1'b0;
    assign i4.valid_in = 1'b0;
    assign i5.valid_in = 1'b0;
`endif

    // Reference: every DUT output is simply the sample taken DELAY edges
    // earlier (counting the current edge), or 0 if fewer samples exist since reset.
    logic [31:0] hist [N][$];
    logic        vhist [$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string phase);
        logic [31:0] exp;
        for (int i = 0; i < N; i++) begin
            if (hist[i].size() >= DLY[i]) exp = hist[i][hist[i].size() - DLY[i]];
            else                          exp = 32'h0;
            if (i != 5) exp = {24'h0, exp[7:0]};
            chk(obs[i], exp, $sformatf("%s_d%0d", phase, DLY[i]));
        end
`ifdef DELAY_CHANNEL_VALID_EN
        chk({31'h0, i2.valid_out},
            {31'h0, (vhist.size() >= 3) ? vhist[vhist.size() - 3] : 1'b0},
            {phase, "_valid_d3"});
`endif
    endtask

    task automatic tick(input string phase);
        @(posedge clk);
        for (int i = 0; i < N; i++) hist[i].push_back(din[i]);
        vhist.push_back(vin);
        #1;
        check_all(phase);
    endtask

    task automatic do_reset(input string phase);
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            hist[i].delete();
            chk(obs[i], 32'h0, $sformatf("%s_async_d%0d", phase, DLY[i]));
        end
        vhist.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) din[i] = 32'h0;
        vin = 1'b0;

        #1 rst = 1'b1;
        #2;
        for (int i = 0; i < N; i++) chk(obs[i], 32'h0, $sformatf("reset_d%0d", DLY[i]));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Incrementing 0x01,0x02,... from the first post-release edge.
        for (int k = 1; k <= 12; k++) begin
            for (int i = 0; i < N; i++) din[i] = k;
            tick("incr");
        end

        // Alternating 0xAA / 0x55.
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < N; i++) din[i] = k[0] ? 32'h55 : 32'hAA;
            tick("alt");
        end

        // Random traffic, one single-cycle valid pulse with 0x7, one X word.
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < N; i++) din[i] = $urandom;
            vin = 1'b0;
            if (k == 5) begin
                din[2] = 32'h7;
                vin    = 1'b1;
            end
            if (k == 20) begin
                din[3] = 32'h0;
                din[3][7:0] = 8'hxx;
            end
            tick("rand");
        end
        vin = 1'b0;
        for (int k = 0; k < 6; k++) tick("drain");

        // Mid-stream reset: in-flight words must never reappear.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) din[i] = $urandom;
            tick("pre_rst");
        end
        do_reset("mid");

        // Constant 0xDEADBEEF: long-latency channel stays 0 through its fill.
        for (int k = 0; k < 110; k++) begin
            for (int i = 0; i < N; i++) din[i] = 32'hDEADBEEF;
            tick("const");
        end

        // 0..63 counter across many pointer wraps, random valid sideband.
        for (int k = 0; k < 128; k++) begin
            for (int i = 0; i < N; i++) din[i] = k % 64;
            vin = $urandom_range(0, 1) == 1;
            tick("wrap");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
